// File: rtl/i2s_pkg.sv
// Shared types for the I2S audio paths: default channel width, the stereo
// word layout and the DAC transmitter state encoding.
package i2s_pkg;

  // Default bits per audio channel.
  localparam int I2S_DATA_W = 16;

  // One stereo sample; left occupies the upper half of the packed word.
  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } stereo_t;

  // Transmitter state, exposed on the top-level debug port.
  typedef enum logic [1:0] {
    WAIT_LEFT = 2'd0,
    LEFT_TX   = 2'd1,
    RIGHT_TX  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/i2s_dac_transmitter_if.sv
// Sample input bus of the I2S DAC transmitter.
//
// Handshake: a word transfers on every rising CLK edge where sample_valid and
// sample_ready are both high. The producer holds sample_in stable while
// sample_valid is high and not yet accepted; sample_ready depends only on
// registered consumer state, never combinationally on sample_valid.
interface i2s_dac_transmitter_if #(
  parameter int DATA_W = i2s_pkg::I2S_DATA_W
);
  logic [2*DATA_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/sample_fifo.sv
// Small synchronous show-ahead FIFO for stereo words, shared by the playback
// and capture paths. Pushes while full and pops while empty are ignored.
module sample_fifo
  import i2s_pkg::*;
#(
  parameter type T     = stereo_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  T            r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == FULL_LEVEL);
  assign o_empty = (o_level == '0);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/i2s_dac_transmitter.sv
// I2S (Philips format) DAC transmitter. Buffers stereo words in a FIFO and
// shifts them out MSB-first on AUD_DACDAT, slaved to the codec's BCLK and
// DACLRCK which are oversampled in the CLK domain.
module i2s_dac_transmitter
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  i2s_dac_transmitter_if.slave        s_bus,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output tx_state_t                   o_dbg_state
);

  localparam int               CNT_W       = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BITS_PER_CH = CNT_W'(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } word_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic                   r_bclk_hist;
  logic                   r_lr_q;
  logic                   r_lr_qq;
  tx_state_t              r_state;
  tx_state_t              w_next_state;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      r_hold;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_dacdat;
  logic                   r_underrun;

  logic                   w_bclk_s;
  logic                   w_lrck_s;
  logic                   w_bclk_rise;
  logic                   w_bclk_fall;
  logic                   w_left_start;
  logic                   w_right_start;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_load_left;
  logic                   w_load_right;
  logic                   w_shift;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  word_t                  w_push_word;
  word_t                  w_head;
  logic [DATA_W-1:0]      w_left_word;
  logic [DATA_W-1:0]      w_right_word;

  // ---------------------------------------------------------------- FIFO
  assign w_push_word        = word_t'(s_bus.sample_in);
  assign s_bus.sample_ready = !RESET && !w_fifo_full;
  assign w_push             = s_bus.sample_valid && s_bus.sample_ready;

  sample_fifo #(
    .T     (word_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  // An empty FIFO at a left start sends a silent frame.
  assign w_left_word  = w_fifo_empty ? '0 : w_head.left;
  assign w_right_word = w_fifo_empty ? '0 : w_head.right;

  // ------------------------------------------ input sync and edge detect
  // Bring BCLK/LRCK into CLK and keep one BCLK history flop for edges.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_bclk_hist <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      r_bclk_hist <= r_bclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrck_s    = r_lrck_sync[SYNC_STAGES-1];
  assign w_bclk_rise = w_bclk_s && !r_bclk_hist;
  assign w_bclk_fall = !w_bclk_s && r_bclk_hist;

  // Sample LRCK on BCLK rise; the two-deep history yields the I2S one-bit
  // delay. Resetting both low means a restart while LRCK is high produces
  // only a right start, which WAIT_LEFT ignores.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lr_q  <= 1'b0;
      r_lr_qq <= 1'b0;
    end else if (w_bclk_rise) begin
      r_lr_q  <= w_lrck_s;
      r_lr_qq <= r_lr_q;
    end
  end

  assign w_left_start  = w_bclk_fall && (r_lr_q != r_lr_qq) && !r_lr_q;
  assign w_right_start = w_bclk_fall && (r_lr_q != r_lr_qq) && r_lr_q;

  // ------------------------------------------------------- state machine
  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= WAIT_LEFT;
    else       r_state <= w_next_state;
  end

  // Next state: a left start always (re)enters LEFT_TX; a right start only
  // matters once a frame is in progress.
  always_comb begin
    w_next_state = r_state;
    if (w_left_start) begin
      w_next_state = LEFT_TX;
    end else if (w_right_start && (r_state != WAIT_LEFT)) begin
      w_next_state = RIGHT_TX;
    end
  end

  // Datapath controls decoded from the current state and the strobes.
  always_comb begin
    w_pop        = 1'b0;
    w_load_left  = 1'b0;
    w_load_right = 1'b0;
    w_shift      = 1'b0;
    if (w_left_start) begin
      w_load_left = 1'b1;
      w_pop       = !w_fifo_empty;
    end else if (w_right_start && (r_state != WAIT_LEFT)) begin
      w_load_right = 1'b1;
    end else if (w_bclk_fall && (r_state != WAIT_LEFT)) begin
      w_shift = 1'b1;
    end
  end

  // Serializer: the MSB leaves on the starting BCLK fall itself, later falls
  // walk down to the LSB and then pad with zeros until the next start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_shift    <= '0;
      r_hold     <= '0;
      r_bit_cnt  <= '0;
      r_dacdat   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load_left && w_fifo_empty;
      if (w_load_left) begin
        r_dacdat  <= w_left_word[DATA_W-1];
        r_shift   <= {w_left_word[DATA_W-2:0], 1'b0};
        r_hold    <= w_right_word;
        r_bit_cnt <= CNT_W'(1);
      end else if (w_load_right) begin
        r_dacdat  <= r_hold[DATA_W-1];
        r_shift   <= {r_hold[DATA_W-2:0], 1'b0};
        r_bit_cnt <= CNT_W'(1);
      end else if (w_shift) begin
        if (r_bit_cnt < BITS_PER_CH) begin
          r_dacdat  <= r_shift[DATA_W-1];
          r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end else begin
          r_dacdat <= 1'b0;
        end
      end else if (w_bclk_fall) begin
        r_dacdat <= 1'b0;
      end
    end
  end

  assign AUD_DACDAT  = r_dacdat;
  assign underrun    = r_underrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for i2s_dac_transmitter: acts as the codec (BCLK = CLK/8),
// captures AUD_DACDAT on every BCLK rise and compares whole frames against
// hand-computed patterns.
`timescale 1ns/1ps
module tb_i2s_dac_transmitter;
  import i2s_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  // ------------------------------------------------ clock / reset / DUT
  logic      clk   = 1'b0;
  logic      rst   = 1'b1;
  logic      bclk  = 1'b0;
  logic      lrck  = 1'b1;
  logic      dacdat;
  logic [2:0] level;
  logic      und;
  tx_state_t dbg;

  i2s_dac_transmitter_if #(.DATA_W(DW)) bus ();

  i2s_dac_transmitter #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .s_bus       (bus),
    .AUD_BCLK    (bclk),
    .AUD_DACLRCK (lrck),
    .AUD_DACDAT  (dacdat),
    .fifo_level  (level),
    .underrun    (und),
    .o_dbg_state (dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------ scoreboard state
  int          total = 0;
  int          bad   = 0;
  int          und_cnt = 0;
  int          bpos = 59;
  int          slot_len = 32;
  int          nbits = 0;
  int          ones = 0;
  logic [63:0] frame_bits = '0;
  logic [63:0] frames_q[$];
  logic [63:0] exp_q[$];

  always @(negedge clk) if (und === 1'b1) und_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [31:0] w);
    return {w[31:16], 16'h0000, w[15:0], 16'h0000};
  endfunction

  // ------------------------------------------------ driver tasks
  // One BCLK period per iteration; LRCK moves on the falling edge and the
  // data line is sampled on the rising edge, like a real codec.
  task automatic run_bclk(input int n);
    logic d;
    for (int k = 0; k < n; k++) begin
      bpos = (bpos + 1) % (2 * slot_len);
      bclk = 1'b0;
      lrck = (bpos >= slot_len);
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      d = dacdat;
      frame_bits = {frame_bits[62:0], d};
      nbits++;
      if (d === 1'b1) ones++;
      if (bpos == 0) begin
        if (nbits == 2 * slot_len) frames_q.push_back(frame_bits);
        nbits = 0;
        frame_bits = '0;
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    int waited;
    waited = 0;
    bus.sample_in    = w;
    bus.sample_valid = 1'b1;
    while (bus.sample_ready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("push_accept", bus.sample_ready, 1'b1);
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic check_frames(input string name);
    logic [63:0] got;
    logic [63:0] exp;
    check({name, "_count"}, frames_q.size(), exp_q.size());
    while (frames_q.size() > 0 && exp_q.size() > 0) begin
      got = frames_q.pop_front();
      exp = exp_q.pop_front();
      check({name, "_frame"}, got, exp);
    end
    frames_q.delete();
    exp_q.delete();
  endtask

  // ------------------------------------------------ vector table
  typedef struct {
    logic [31:0] word;
    logic [63:0] frame;
  } vec_t;
  vec_t vecs[5];

  logic [31:0] bp[5];
  int          und0;

  initial begin
    vecs[0] = '{32'hA5C3_0F0F, 64'hA5C3_0000_0F0F_0000};
    vecs[1] = '{32'hFFFF_0001, 64'hFFFF_0000_0001_0000};
    vecs[2] = '{32'h8000_7FFF, 64'h8000_0000_7FFF_0000};
    vecs[3] = '{32'h1234_ABCD, 64'h1234_0000_ABCD_0000};
    vecs[4] = '{32'h0000_FFFF, 64'h0000_0000_FFFF_0000};
    bp[0] = 32'h1111_2222; bp[1] = 32'h3333_4444; bp[2] = 32'h5555_6666;
    bp[3] = 32'h7777_8888; bp[4] = 32'h9999_AAAA;

    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;

    // Reset values, with LRCK high so release lands in a right slot.
    repeat (3) @(negedge clk);
    check("rst_ready", bus.sample_ready, 1'b0);
    check("rst_dacdat", dacdat, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_underrun", und, 1'b0);
    check("rst_state", dbg, WAIT_LEFT);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.sample_ready, 1'b1);

    // Startup alignment: data waiting, but nothing leaves before a left start.
    push_word(vecs[0].word);
    check("startup_level", level, 3'd1);
    run_bclk(5);
    check("startup_zero", ones, 0);
    check("startup_state", dbg, WAIT_LEFT);
    check("startup_underrun", und_cnt, 0);
    frames_q.delete();

    // Basic frames from the table, one word per frame.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) push_word(vecs[i].word);
      exp_q.push_back(vecs[i].frame);
      run_bclk(64);
      check_frames("table");
    end
    check("table_underrun", und_cnt, 0);

    // Underrun: two silent frames, one pulse per left start.
    und0 = und_cnt;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h0);
    run_bclk(128);
    check_frames("underrun");
    check("underrun_pulses", und_cnt - und0, 2);
    check("underrun_level", level, 3'd0);

    // Short 8-bit slots: unsent bits are dropped, next start reloads.
    slot_len = 8;
    und0 = und_cnt;
    push_word(32'hC3A5_F00F);
    exp_q.push_back(64'hC3F0);
    run_bclk(16);
    check_frames("short1");
    push_word(32'h8001_0180);
    exp_q.push_back(64'h8001);
    run_bclk(16);
    check_frames("short2");
    check("short_underrun", und_cnt - und0, 0);
    slot_len = 32;

    // Backpressure: fifth word refused while full.
    for (int k = 0; k < 5; k++) begin
      bus.sample_in    = bp[k];
      bus.sample_valid = 1'b1;
      check("bp_ready", bus.sample_ready, (k < 4));
      @(negedge clk);
      check("bp_level", level, (k < 4) ? (k + 1) : 4);
    end
    repeat (3) @(negedge clk);
    check("bp_hold_level", level, 3'd4);
    check("bp_ready_low", bus.sample_ready, 1'b0);
    bus.sample_valid = 1'b0;
    und0 = und_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(frame_of(bp[k]));
    exp_q.push_back(64'h0);
    run_bclk(320);
    check_frames("bp");
    check("bp_underrun", und_cnt - und0, 1);

    // Push offered against a full FIFO while the left-start pop happens.
    push_word(32'hCAFE_0001);
    push_word(32'hCAFE_0002);
    push_word(32'hCAFE_0003);
    push_word(32'hCAFE_0004);
    check("sim_full_level", level, 3'd4);
    und0 = und_cnt;
    fork
      run_bclk(320);
      begin
        push_word(32'hBEEF_0005);
        check("sim_level_after", level, 3'd4);
      end
    join
    exp_q.push_back(frame_of(32'hCAFE_0001));
    exp_q.push_back(frame_of(32'hCAFE_0002));
    exp_q.push_back(frame_of(32'hCAFE_0003));
    exp_q.push_back(frame_of(32'hCAFE_0004));
    exp_q.push_back(frame_of(32'hBEEF_0005));
    check_frames("sim");
    check("sim_underrun", und_cnt - und0, 0);

    // Reset in the middle of the left slot.
    push_word(32'hF0F0_1234);
    push_word(32'h0F0F_5678);
    run_bclk(7);
    check("mid_state", dbg, LEFT_TX);
    rst = 1'b1;
    #1;
    check("mid_rst_dacdat", dacdat, 1'b0);
    check("mid_rst_level", level, 3'd0);
    check("mid_rst_ready", bus.sample_ready, 1'b0);
    check("mid_rst_state", dbg, WAIT_LEFT);
    @(negedge clk);
    rst = 1'b0;
    frame_bits = '0;
    nbits = 0;
    ones = 0;
    run_bclk(57);
    check("mid_rest_zero", ones, 0);
    check("mid_no_frame", frames_q.size(), 0);
    check("mid_level", level, 3'd0);
    push_word(32'h6996_A55A);
    exp_q.push_back(frame_of(32'h6996_A55A));
    run_bclk(64);
    check_frames("mid_resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_dac_transmitter.md
Name: i2s_dac_transmitter

Overview:
- Playback-direction counterpart to the microphone capture path.
- Accepts 32-bit stereo words {left[15:0], right[15:0]} through a valid/ready handshake and buffers them in a small FIFO.
- Serializes the buffered words onto the codec DAC data line in Philips I2S format.
- The codec is the bus master: BCLK and DACLRCK are inputs, oversampled in the CLK domain.

Parameters:
- DATA_W, 16: bits per channel; the stereo word is 2*DATA_W.
- FIFO_DEPTH, 4: stereo words buffered; must be a power of two, at least 2.
- SYNC_STAGES, 2: flip-flop stages on the BCLK and DACLRCK inputs.

Ports:
- CLK  in  1  system clock; must be at least 8x the AUD_BCLK frequency.
- RESET  in  1  asynchronous, active-high reset.
- sample_in  in  2*DATA_W  stereo word {left, right}.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a word this cycle.
- AUD_BCLK  in  1  codec bit clock.
- AUD_DACLRCK  in  1  codec DAC word select; low means left channel.
- AUD_DACDAT  out  1  serial data to the codec.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- underrun  out  1  one-CLK pulse when a left-channel start finds the FIFO empty.

Behaviour:
- Reset values: AUD_DACDAT=0, sample_ready=0 while RESET is asserted and 1 on the first cycle after, fifo_level=0, underrun=0, FIFO emptied, shift register=0, bit counter=0, state=WAIT_LEFT.
- Input synchronization:
  - AUD_BCLK and AUD_DACLRCK each pass through SYNC_STAGES flip-flops, plus one history flop for edge detection.
  - bclk_rise and bclk_fall are single-CLK strobes.
- LRCK sampling: on each bclk_rise, lr_q<=lrck_sync and lr_qq<=lr_q.
- Channel-start detection (I2S one-bit delay): a channel starts on a bclk_fall where lr_q!=lr_qq. The new channel is left if lr_q==0, right if lr_q==1.
- Handshake:
  - Push occurs when sample_valid && sample_ready.
  - sample_ready = (fifo_level<FIFO_DEPTH). It depends on registered count only.
  - Push and pop in the same cycle: both take effect and the level is unchanged.
  - sample_in is ignored when sample_ready=0.
- State machine (advances only on the bclk_fall strobe):
  - WAIT_LEFT: AUD_DACDAT=0. On a left start, go to LEFT_TX.
  - Left start, FIFO non-empty: pop one word. Shift register takes the left half, hold register takes the right half. Drive the left MSB on the same bclk_fall.
  - Left start, FIFO empty: load zeros into both halves and pulse underrun for one CLK.
  - LEFT_TX: on each subsequent bclk_fall, drive the next bit MSB-first. After the LSB, drive 0 for any remaining slots (frames wider than DATA_W are zero-padded). On a right start, load the hold register, drive its MSB, go to RIGHT_TX.
  - RIGHT_TX: same shifting rules. On a left start, perform the left-start load/pop as above and go to LEFT_TX.
  - Unexpected start: a left start seen while in LEFT_TX, or a right start seen while in RIGHT_TX, restarts the channel from the matching state. This is a glitch-recovery case.
- AUD_DACDAT is registered and changes only in the CLK cycle of a bclk_fall strobe. Latency from the synchronized falling edge to pin is 1 CLK.
- Short frames: if a channel ends before DATA_W bits, the remaining bits are discarded. The next start reloads.
- Reset mid-frame: output returns to 0 immediately. No partial word is emitted; transmission resumes only at the next left start.
- Pop timing: the pop happens only at a left start, so a stereo pair is never split across frames.

Decomposition:
- Package i2s_pkg holds:
  - the DATA_W default;
  - typedef stereo_t, a packed struct {logic [DATA_W-1:0] left, right};
  - the tx state enum {WAIT_LEFT, LEFT_TX, RIGHT_TX}.
- Sub-module sample_fifo: synchronous FIFO of stereo_t with push, pop, full, empty and level, async active-high reset. It is reusable on the capture side.
- Synchronizers and edge detect stay inline.

Test Plan:
- Basic frame: push 0xA5C3_0F0F with BCLK = CLK/8 and 32 BCLK per frame, starting from left. DACDAT over the left slot is 1010010111000011 beginning one BCLK after the LRCK fall, then 16 zeros. The right slot is 0000111100001111.
- Underrun: no data and two frames elapse. underrun pulses exactly once per left start, DACDAT stays 0, fifo_level=0.
- Backpressure: push 5 words back-to-back with no frames running. sample_ready drops after the 4th push, the 5th word is not accepted, fifo_level=4. Words are then emitted in push order.
- Simultaneous push and pop: FIFO full, push offered on the same CLK cycle as the left-start pop. fifo_level stays 4 and the new word is accepted.
- Reset mid-frame: assert RESET at bit 7 of the left slot. DACDAT=0 immediately, FIFO empty, the first non-zero output follows a fresh push and the next LRCK fall.
- Startup alignment: release reset while LRCK is high (right slot). DACDAT stays 0 until the first left start, then correct data appears.
